// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream source blocks: output buffer depth
// and the occupancy rule used when deciding whether another read fits.
package axis_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // True when buffered + in-flight beats, less the beat leaving this cycle, still leave a free slot.
  function automatic logic has_room(input logic [BUF_CNT_W-1:0] cnt,
                                    input logic                 inflight,
                                    input logic                 pop);
    logic [BUF_CNT_W:0] occ;
    occ = {1'b0, cnt} + {{BUF_CNT_W{1'b0}}, inflight} - {{BUF_CNT_W{1'b0}}, pop};
    return occ < (BUF_CNT_W + 1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/axis_fifo_source_chk.sv
// Protocol and occupancy checks for axis_fifo_source.
module axis_fifo_source_chk
  import axis_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic [BUF_CNT_W-1:0] buf_count,
  input logic                 inflight,
  input logic                 fifo_rd_en,
  input logic                 fifo_empty,
  input logic                 m_tvalid,
  input logic                 m_tready,
  input logic [DWIDTH-1:0]    m_tdata,
  input logic                 m_tlast
);

  occupancy_a: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, buf_count} + {{BUF_CNT_W{1'b0}}, inflight}) <= (BUF_CNT_W + 1)'(BUF_DEPTH));

  rd_when_empty_a: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty));

  stall_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast)));

endmodule

// File: rtl/axis_out_buf.sv
// Two-entry push/pop buffer with registered head, valid and count; slot0 is
// always the head, so the head data is a plain register.
module axis_out_buf
  import axis_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic                 valid,
  output logic [BUF_CNT_W-1:0] count
);

  logic [W-1:0]         slot0_r;
  logic [W-1:0]         slot1_r;
  logic [BUF_CNT_W-1:0] count_r;
  logic                 valid_r;
  logic [BUF_CNT_W-1:0] count_nxt_s;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop})
      2'b10:   count_nxt_s = count_r + BUF_CNT_W'(1);
      2'b01:   count_nxt_s = count_r - BUF_CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage shifts toward slot0 on pop so ordering is preserved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == BUF_CNT_W'(0)) slot0_r <= din;
          else                          slot1_r <= din;
        end
        2'b01: slot0_r <= slot1_r;
        2'b11: begin
          if (count_r == BUF_CNT_W'(1)) begin
            slot0_r <= din;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= din;
          end
        end
        default: ;
      endcase
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != BUF_CNT_W'(0));
    end
  end

  assign head  = slot0_r;
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/axis_fifo_source.sv
// Drains a registered-read FIFO into an AXI4-Stream master, framing packets of
// PKT_LEN beats and counting completed packets.
module axis_fifo_source
  import axis_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  output logic                      fifo_rd_en,
  input  logic [DWIDTH-1:0]         fifo_dout,
  input  logic                      fifo_empty,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DWIDTH-1:0]         m_tdata,
  output logic                      m_tlast,
  output logic [CNT_W-1:0]          pkt_count,
  output logic [$clog2(PKT_LEN):0]  beat_idx
);

  localparam int            BW       = $clog2(PKT_LEN) + 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);

  logic                 pop_s;
  logic                 rd_s;
  logic                 inflight_r;
  logic [BUF_CNT_W-1:0] buf_count;
  logic [BW-1:0]        beat_idx_r;
  logic [CNT_W-1:0]     pkt_count_r;

  assign pop_s = m_tvalid & m_tready;
  // Counting the leaving beat lets a full pipeline keep reading every cycle under tready.
  assign rd_s       = rst_n & en & ~fifo_empty & has_room(buf_count, inflight_r, pop_s);
  assign fifo_rd_en = rd_s;

  // Marks the cycle on which the FIFO's read data is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) inflight_r <= 1'b0;
    else        inflight_r <= rd_s;
  end

  axis_out_buf #(.W(DWIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_r),
    .din   (fifo_dout),
    .pop   (pop_s),
    .head  (m_tdata),
    .valid (m_tvalid),
    .count (buf_count)
  );

  assign m_tlast = m_tvalid & (beat_idx_r == LAST_IDX);

  // Beat position and packet count advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_idx_r  <= '0;
      pkt_count_r <= '0;
    end else if (pop_s) begin
      if (m_tlast) begin
        beat_idx_r  <= '0;
        pkt_count_r <= pkt_count_r + CNT_W'(1);
      end else begin
        beat_idx_r  <= beat_idx_r + BW'(1);
      end
    end
  end

  assign beat_idx  = beat_idx_r;
  assign pkt_count = pkt_count_r;

  axis_fifo_source_chk #(.DWIDTH(DWIDTH)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .buf_count  (buf_count),
    .inflight   (inflight_r),
    .fifo_rd_en (rd_s),
    .fifo_empty (fifo_empty),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast)
  );

endmodule

// File: doc/axis_fifo_source.md
Name: axis_fifo_source

Overview:
- Downstream stage of the stream FIFO. Drains the FIFO's read port (rd_en/dout/empty, one-cycle registered read latency) and presents the data as an AXI4-Stream master (tvalid/tready/tdata/tlast).
- Hides the FIFO read latency with a 2-entry output buffer, so sustained throughput is 1 beat/clk under continuous tready.
- Generates tlast every PKT_LEN beats and counts completed packets.

Parameters:
- DWIDTH, 16, data width; must equal the FIFO DWIDTH.
- PKT_LEN, 4, beats per packet; legal range >=1; tlast on beat PKT_LEN-1.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  read enable; 0 stops new FIFO reads, but buffered/in-flight beats still drain
- fifo_rd_en  out  1  read strobe to the FIFO
- fifo_dout  in  DWIDTH  FIFO read data, valid the cycle after an accepted read
- fifo_empty  in  1  FIFO empty flag
- m_tvalid  out  1  AXIS valid
- m_tready  in  1  AXIS ready
- m_tdata  out  DWIDTH  AXIS data
- m_tlast  out  1  AXIS last beat of packet
- pkt_count  out  CNT_W  completed packets, wraps modulo 2^CNT_W
- beat_idx  out  $clog2(PKT_LEN)+1  index of the current head beat within its packet

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock clk.
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0
  - buffer count=0, inflight=0
  - beat_idx=0, pkt_count=0
  - fifo_rd_en=0 while rst_n=0
- Handshakes:
  - pop = m_tvalid & m_tready.
  - An accepted read is fifo_rd_en & !fifo_empty; it sets inflight=1 for exactly the next cycle.
  - On that next cycle, fifo_dout is captured into the buffer tail.
- Read issue (combinational):
  - fifo_rd_en = rst_n & en & !fifo_empty & ((count + inflight - pop) < 2).
  - fifo_rd_en depends combinationally on m_tready; this path is intended.
  - Never assert fifo_rd_en while fifo_empty=1.
- Output buffer:
  - 2-entry FIFO ordering; head drives m_tdata.
  - m_tvalid = (count != 0), registered.
  - Same-cycle push and pop: count is unchanged and order is preserved.
  - A push into an empty buffer makes m_tvalid high the following cycle.
  - Latency: FIFO non-empty -> fifo_rd_en same cycle -> m_tvalid 2 cycles after that rd_en cycle.
- Overflow guarantee: count + inflight never exceeds 2; an assertion in the RTL checks this.
- AXIS rules:
  - m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0.
  - m_tvalid never drops without a pop.
- tlast and counters:
  - m_tlast = m_tvalid & (beat_idx == PKT_LEN-1).
  - On pop: beat_idx increments, wrapping to 0 after PKT_LEN-1.
  - On a pop with m_tlast=1: pkt_count increments, wrapping naturally.
  - PKT_LEN=1: every beat has tlast.
- en deassertion: takes effect the same cycle for new reads. An in-flight read still lands. The buffer keeps presenting data until drained.
- FIFO going empty mid-packet: m_tvalid drops after the buffer drains; beat_idx holds, and the packet resumes when data returns. No tlast is forced.
- Reset mid-operation: buffered and in-flight beats are discarded, and beat_idx and pkt_count are cleared. The FIFO shares rst_n, so no stale read returns after reset.

Decomposition:
- Shared package axis_pkg: AXIS beat struct/typedef {tdata, tlast} parameterised by DWIDTH; localparam BUF_DEPTH=2.
- Sub-module axis_out_buf: the 2-entry push/pop buffer with count output, reusable for other AXIS sources.
- The top holds the read-issue logic, the inflight flag and the tlast/packet counters.

Test Plan:
- Streaming: FIFO preloaded with 0x0001..0x0008, m_tready=1, en=1, PKT_LEN=4 -> beats 0x0001..0x0008 on consecutive cycles, no bubbles after the first; tlast on 0x0004 and 0x0008; pkt_count=2.
- Backpressure: m_tready toggles 1,0,0,1,0,1... on a 6-word stream -> data/tlast held stable during stalls, no loss or duplication, and count+inflight<=2 every cycle.
- Underflow: 2 words written, FIFO then empty for 5 cycles, then 2 more words -> m_tvalid low during the gap; beat_idx=2 held; tlast on the 4th word.
- Enable gating: en=0 while the FIFO holds 3 words -> fifo_rd_en stays 0 and m_tvalid stays 0; set en=1 -> first beat 2 cycles later.
- Reset mid-packet: assert rst_n=0 for 1 cycle after 2 beats of a packet -> next cycle m_tvalid=0, beat_idx=0, pkt_count=0; a fresh stream then gets tlast on its 4th beat.
- PKT_LEN=1 variant: 3 words -> m_tlast=1 on every beat and pkt_count=3.
